// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: CP0 exception interface between the exception front end
// (master, initiating side) and the CP0 register file (slave).
// The master drives the exception request/cause/EPC/write-enable and reads
// the CP0 status word and EPC register back for qualification and eret.
interface exc_ctrl_if;
    logic        exc_req;
    logic        exc_eret;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        cp0_we;
    logic [31:0] status;
    logic [31:0] epc;

    modport master (
        output exc_req,
        output exc_eret,
        output exc_cause,
        output exc_pc,
        output cp0_we,
        input  status,
        input  epc
    );

    modport slave (
        input  exc_req,
        input  exc_eret,
        input  exc_cause,
        input  exc_pc,
        input  cp0_we,
        output status,
        output epc
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt front end for the MIPS core.
// Collects decode-stage traps (syscall, break, taken teq, eret) and level
// irq lines, qualifies them against CP0 status, picks one event by priority
// and walks IDLE -> SIGNAL -> REDIRECT, stalling and flushing fetch meanwhile.
// Optional build macro IRQ_SYNC_EN: adds a 2-flop synchronizer on every irq
// line ahead of the rising-edge detector (2 extra cycles of irq latency).
module exc_ctrl #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [31:0]        pc_i,
    input  logic               syscall_i,
    input  logic               break_i,
    input  logic               teq_i,
    input  logic               eret_i,
    input  logic [NUM_IRQ-1:0] irq,
    exc_ctrl_if.master         cp0,
    output logic               stall,
    output logic               flush,
    output logic [31:0]        pc_redirect,
    output logic               busy
);

    localparam logic [4:0] CAUSE_INT = 5'd0;
    localparam logic [4:0] CAUSE_SYS = 5'd8;
    localparam logic [4:0] CAUSE_BP  = 5'd9;
    localparam logic [4:0] CAUSE_TR  = 5'd13;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SIGNAL   = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    localparam int SRC_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [1:0]         state;

    // irq path
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] irq_pend;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] irq_qual;

    // qualified synchronous sources
    logic               ie;
    logic               eret_qual;
    logic               sys_qual;
    logic               brk_qual;
    logic               teq_qual;

    // arbitration result
    logic               ev_any;
    logic [4:0]         ev_cause;
    logic               ev_eret;
    logic               ev_irq;
    logic [SRC_W-1:0]   ev_idx;

    // event latches, captured when leaving IDLE
    logic [4:0]         cause_q;
    logic [31:0]        pc_q;
    logic               eret_q;
    logic               src_irq_q;
    logic [SRC_W-1:0]   src_idx_q;

    // only a handful of status bits are meaningful here; fold the rest away
    logic               status_unused;
    assign status_unused = ^cp0.status;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irq_s1;
    logic [NUM_IRQ-1:0] irq_s2;

    // two-flop synchronizer for asynchronous irq lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= irq;
            irq_s2 <= irq_s1;
        end
    end

    assign irq_in = irq_s2;
`else
    assign irq_in = irq;
`endif

    assign irq_rise = irq_in & ~irq_prev;

    // previous irq level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_in;
        end
    end

    // clear the pending bit of the irq being delivered in SIGNAL
    always_comb begin
        irq_clr = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (state == SIGNAL && src_irq_q && int'(src_idx_q) == k) begin
                irq_clr[k] = 1'b1;
            end
        end
    end

    // pending irq bits: a new edge wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend <= '0;
        end else begin
            irq_pend <= (irq_pend & ~irq_clr) | irq_rise;
        end
    end

    assign ie        = cp0.status[0];
    assign eret_qual = instr_valid & eret_i;
    assign sys_qual  = instr_valid & syscall_i & ie & cp0.status[1];
    assign brk_qual  = instr_valid & break_i   & ie & cp0.status[2];
    assign teq_qual  = instr_valid & teq_i     & ie & cp0.status[3];

    // irq k is deliverable only when globally enabled and individually unmasked
    always_comb begin
        irq_qual = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            irq_qual[k] = ie & cp0.status[8 + k] & irq_pend[k];
        end
    end

    // priority: eret > syscall > break > teq > irq (lowest index first)
    always_comb begin
        ev_any   = 1'b0;
        ev_cause = CAUSE_INT;
        ev_eret  = 1'b0;
        ev_irq   = 1'b0;
        ev_idx   = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_qual[k]) begin
                ev_any   = 1'b1;
                ev_cause = CAUSE_INT;
                ev_irq   = 1'b1;
                ev_idx   = SRC_W'(k);
            end
        end
        if (teq_qual) begin
            ev_any   = 1'b1;
            ev_cause = CAUSE_TR;
            ev_irq   = 1'b0;
        end
        if (brk_qual) begin
            ev_any   = 1'b1;
            ev_cause = CAUSE_BP;
            ev_irq   = 1'b0;
        end
        if (sys_qual) begin
            ev_any   = 1'b1;
            ev_cause = CAUSE_SYS;
            ev_irq   = 1'b0;
        end
        if (eret_qual) begin
            ev_any   = 1'b1;
            ev_cause = CAUSE_INT;
            ev_eret  = 1'b1;
            ev_irq   = 1'b0;
        end
    end

    // delivery FSM; event details are latched once when leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cause_q   <= '0;
            pc_q      <= '0;
            eret_q    <= 1'b0;
            src_irq_q <= 1'b0;
            src_idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_any) begin
                        cause_q   <= ev_cause;
                        pc_q      <= pc_i;
                        eret_q    <= ev_eret;
                        src_irq_q <= ev_irq;
                        src_idx_q <= ev_idx;
                        state     <= SIGNAL;
                    end
                end
                SIGNAL:   state <= REDIRECT;
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // CP0 side is active only in SIGNAL; CP0 commits on the negedge inside it
    always_comb begin
        cp0.exc_req   = (state == SIGNAL);
        cp0.cp0_we    = (state == SIGNAL);
        cp0.exc_eret  = (state == SIGNAL) & eret_q;
        cp0.exc_cause = (state == SIGNAL) ? cause_q : 5'd0;
        cp0.exc_pc    = (state == SIGNAL) ? pc_q : 32'd0;
    end

    // fetch control: stall from detection through REDIRECT, flush in REDIRECT
    always_comb begin
        busy        = (state != IDLE);
        stall       = ~rst & (((state == IDLE) & ev_any) | (state != IDLE));
        flush       = (state == REDIRECT);
        pc_redirect = 32'd0;
        if (state == REDIRECT) begin
            pc_redirect = eret_q ? cp0.epc : EXC_VECTOR;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl. Stimulus pushes the expected
// CP0 transaction (cycle, cause, eret, EPC, redirect target) into a queue;
// a negedge monitor pops and compares whenever exc_req is seen, and checks
// the following REDIRECT cycle.
module tb_exc_ctrl;
    localparam int          NUM_IRQ = 4;
    localparam logic [31:0] VEC     = 32'h0000_0004;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        int          cyc;
        logic [4:0]  cause;
        bit          chk_cause;
        logic        eret;
        logic [31:0] pc;
        logic [31:0] redir;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               instr_valid;
    logic [31:0]        pc_i;
    logic               syscall_i, break_i, teq_i, eret_i;
    logic [NUM_IRQ-1:0] irq;
    logic               stall, flush, busy;
    logic [31:0]        pc_redirect;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    bit          redir_pend = 0;
    logic [31:0] redir_exp  = '0;

    exc_ctrl_if cp0_if ();

    exc_ctrl #(.NUM_IRQ(NUM_IRQ), .EXC_VECTOR(VEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .pc_i        (pc_i),
        .syscall_i   (syscall_i),
        .break_i     (break_i),
        .teq_i       (teq_i),
        .eret_i      (eret_i),
        .irq         (irq),
        .cp0         (cp0_if.master),
        .stall       (stall),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input string msg);
        n_tot++;
        $display("FAIL %s: %s", name, msg);
    endtask

    task automatic push(input int c, input logic [4:0] cause, input bit cc,
                        input logic eret, input logic [31:0] pc, input logic [31:0] rd);
        exp_t e;
        e.cyc = c; e.cause = cause; e.chk_cause = cc;
        e.eret = eret; e.pc = pc; e.redir = rd;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b0 && stall === 1'b0) return;
            step();
        end
        fail(name, "timeout waiting for idle");
    endtask

    // monitor: compare each delivered exception and its redirect cycle
    always @(negedge clk) begin
        if (rst) begin
            redir_pend = 0;
        end else begin
            if (redir_pend) begin
                chk("redir_flush", flush, 1'b1);
                chk("redir_stall", stall, 1'b1);
                chk("redir_pc", pc_redirect, redir_exp);
                chk("redir_req_low", cp0_if.exc_req, 1'b0);
                redir_pend = 0;
            end else if (flush !== 1'b0) begin
                fail("flush_unexpected", "flush asserted without preceding exc_req");
            end
            if (cp0_if.exc_req === 1'b1) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL exc_unexpected: cause %0d pc %h at cycle %0d, none expected",
                             cp0_if.exc_cause, cp0_if.exc_pc, cyc);
                    n_tot++;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("exc_cycle", cyc, e.cyc);
                    if (e.chk_cause) chk("exc_cause", cp0_if.exc_cause, e.cause);
                    chk("exc_eret", cp0_if.exc_eret, e.eret);
                    chk("exc_pc", cp0_if.exc_pc, e.pc);
                    chk("cp0_we", cp0_if.cp0_we, 1'b1);
                    chk("sig_stall", stall, 1'b1);
                    chk("sig_busy", busy, 1'b1);
                    redir_pend = 1;
                    redir_exp  = e.redir;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        instr_valid = 0; pc_i = '0; syscall_i = 0; break_i = 0; teq_i = 0; eret_i = 0;
        irq = '0; cp0_if.status = '0; cp0_if.epc = '0; rst = 1;
        step(); step();

        // reset state
        chk("rst_exc_req", cp0_if.exc_req, 1'b0);
        chk("rst_cp0_we", cp0_if.cp0_we, 1'b0);
        chk("rst_exc_eret", cp0_if.exc_eret, 1'b0);
        chk("rst_exc_cause", cp0_if.exc_cause, 5'd0);
        chk("rst_exc_pc", cp0_if.exc_pc, 32'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_pc_redirect", pc_redirect, 32'd0);
        chk("rst_busy", busy, 1'b0);
        rst = 0;
        step();

        // single syscall
        cp0_if.status = 32'h0000_000F; instr_valid = 1; syscall_i = 1; pc_i = 32'h0040_0010;
        #1 chk("t1_stall_comb", stall, 1'b1);
        push(cyc + 1, 5'd8, 1, 1'b0, 32'h0040_0010, VEC);
        step();
        instr_valid = 0; syscall_i = 0;
        wait_idle("t1_idle");

        // syscall beats break and teq
        instr_valid = 1; syscall_i = 1; break_i = 1; teq_i = 1; pc_i = 32'h0040_0020;
        push(cyc + 1, 5'd8, 1, 1'b0, 32'h0040_0020, VEC);
        step();
        instr_valid = 0; syscall_i = 0; break_i = 0; teq_i = 0;
        wait_idle("t2_idle");

        // break enabled, teq enabled: break wins
        cp0_if.status = 32'h0000_000D; instr_valid = 1; break_i = 1; teq_i = 1; pc_i = 32'h0040_0028;
        push(cyc + 1, 5'd9, 1, 1'b0, 32'h0040_0028, VEC);
        step();
        instr_valid = 0; break_i = 0; teq_i = 0;
        wait_idle("t3a_idle");

        // break masked, teq enabled: teq taken
        cp0_if.status = 32'h0000_0009; instr_valid = 1; break_i = 1; teq_i = 1; pc_i = 32'h0040_0030;
        push(cyc + 1, 5'd13, 1, 1'b0, 32'h0040_0030, VEC);
        step();
        instr_valid = 0; break_i = 0; teq_i = 0;
        wait_idle("t3b_idle");

        // eret is unconditional and redirects to epc
        cp0_if.status = 32'h0; cp0_if.epc = 32'h0040_0200;
        instr_valid = 1; eret_i = 1; pc_i = 32'h0040_0040;
        push(cyc + 1, 5'd0, 0, 1'b1, 32'h0040_0040, 32'h0040_0200);
        step();
        instr_valid = 0; eret_i = 0;
        wait_idle("t4_idle");

        // masked syscall is dropped
        cp0_if.status = 32'h0000_0001; instr_valid = 1; syscall_i = 1; pc_i = 32'h0040_0050;
        #1 chk("t5_stall_masked", stall, 1'b0);
        step();
        instr_valid = 0; syscall_i = 0;
        step();
        chk("t5_busy_masked", busy, 1'b0);

        // break in flight, irq0 rises, syscall during SIGNAL/REDIRECT ignored
        cp0_if.status = 32'h0000_0107; instr_valid = 1; break_i = 1; pc_i = 32'h0040_0060;
        push(cyc + 1, 5'd9, 1, 1'b0, 32'h0040_0060, VEC);
        step();
        break_i = 0; syscall_i = 1; irq[0] = 1;
        step();
        chk("t6_busy_redirect", busy, 1'b1);
        step();
        syscall_i = 0; instr_valid = 0; pc_i = 32'h0040_0100;
        push(cyc + 1 + SYNC_LAT, 5'd0, 1, 1'b0, 32'h0040_0100, VEC);
        step();
        irq[0] = 0;
        repeat (SYNC_LAT) step();
        wait_idle("t6_idle");

        // masked irq1 stays pending until unmasked
        cp0_if.status = 32'h0000_0107; irq[1] = 1;
        repeat (6) step();
        chk("t7_busy_masked", busy, 1'b0);
        chk("t7_stall_masked", stall, 1'b0);
        pc_i = 32'h0040_0110; cp0_if.status = 32'h0000_0207;
        push(cyc + 1, 5'd0, 1, 1'b0, 32'h0040_0110, VEC);
        step();
        irq[1] = 0;
        wait_idle("t7_idle");
        step();

        // irq1 single-cycle pulse latency
        cp0_if.status = 32'h0000_0201; pc_i = 32'h0040_0118; irq[1] = 1;
        push(cyc + 2 + SYNC_LAT, 5'd0, 1, 1'b0, 32'h0040_0118, VEC);
        step();
        irq[1] = 0;
        repeat (8) step();

        // reset asserted mid-SIGNAL
        cp0_if.status = 32'h0000_000F; irq[2] = 1;
        repeat (2 + SYNC_LAT) step();
        instr_valid = 1; syscall_i = 1; pc_i = 32'h0040_0120;
        step();
        instr_valid = 0; syscall_i = 0;
        rst = 1; irq[2] = 0;
        #1;
        chk("t9_exc_req", cp0_if.exc_req, 1'b0);
        chk("t9_cp0_we", cp0_if.cp0_we, 1'b0);
        chk("t9_exc_cause", cp0_if.exc_cause, 5'd0);
        chk("t9_exc_pc", cp0_if.exc_pc, 32'd0);
        chk("t9_busy", busy, 1'b0);
        chk("t9_stall", stall, 1'b0);
        chk("t9_flush", flush, 1'b0);
        step(); step();
        rst = 0; cp0_if.status = 32'h0000_040F;
        repeat (6) step();
        chk("t9_busy_after", busy, 1'b0);
        chk("t9_stall_after", stall, 1'b0);

        repeat (4) step();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
